// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV decode stage with valid/ready on both sides.
// Decodes operands, immediates, load/store and optional M-extension ops,
// flags illegal encodings, interlocks on load-use hazards and counts stall
// cycles. One cycle of latency from accept to out_valid.
module id_stage_pipe #(
  parameter int XLEN        = 32,
  parameter bit EN_M        = 1'b1,
  parameter bit EN_LU_STALL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic            illegal_o,
  output logic [31:0]     stall_cnt_o
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_funct3 = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_funct7 = inst_i[31:25];

  // Sign-extended immediates
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [5:0]      w_shamt;
  logic            w_shamt_ok;

  assign w_imm_i = XLEN'($signed(inst_i[31:20]));
  assign w_imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign w_imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                  inst_i[30:21], 1'b0}));

  // RV32 has a 5-bit shamt, so bit 25 set is a reserved encoding there
  assign w_shamt    = IS64 ? inst_i[25:20] : {1'b0, inst_i[24:20]};
  assign w_shamt_ok = IS64 || !inst_i[25];

  // Raw decode results before the illegal mask
  logic            w_legal;
  logic            w_rs1_use;
  logic            w_rs2_use;
  logic            w_wen_raw;
  logic            w_mren_raw;
  logic            w_mwen_raw;
  logic [XLEN-1:0] w_op1_raw;
  logic [XLEN-1:0] w_op2_raw;
  logic [XLEN-1:0] w_sdata_raw;

  // Per-opcode legality check and operand routing
  always_comb begin
    w_legal     = 1'b0;
    w_rs1_use   = 1'b0;
    w_rs2_use   = 1'b0;
    w_wen_raw   = 1'b0;
    w_mren_raw  = 1'b0;
    w_mwen_raw  = 1'b0;
    w_op1_raw   = '0;
    w_op2_raw   = '0;
    w_sdata_raw = '0;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_rs1_use = 1'b1;
        w_wen_raw = 1'b1;
        w_op1_raw = rs1_data_i;
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_op2_raw = XLEN'(w_shamt);
          w_legal   = w_shamt_ok &&
                      ((inst_i[31:26] == 6'b000000) ||
                       (w_funct3 == 3'b101 && inst_i[31:26] == 6'b010000));
        end else begin
          w_op2_raw = w_imm_i;
          w_legal   = 1'b1;
        end
      end
      OPC_OP: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_wen_raw = 1'b1;
        w_op1_raw = rs1_data_i;
        w_op2_raw = rs2_data_i;
        w_legal   = (w_funct7 == 7'b0000000) ||
                    (w_funct7 == 7'b0100000 &&
                     (w_funct3 == 3'b000 || w_funct3 == 3'b101)) ||
                    (w_funct7 == 7'b0000001 && EN_M);
      end
      OPC_BRANCH: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_op1_raw = rs1_data_i;
        w_op2_raw = rs2_data_i;
        w_legal   = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
      end
      OPC_JAL: begin
        w_wen_raw = 1'b1;
        w_op1_raw = w_imm_j;
        w_legal   = 1'b1;
      end
      OPC_JALR: begin
        w_rs1_use = 1'b1;
        w_wen_raw = 1'b1;
        w_op1_raw = rs1_data_i;
        w_op2_raw = w_imm_i;
        w_legal   = (w_funct3 == 3'b000);
      end
      OPC_LUI: begin
        w_wen_raw = 1'b1;
        w_op1_raw = w_imm_u;
        w_legal   = 1'b1;
      end
      OPC_AUIPC: begin
        w_wen_raw = 1'b1;
        w_op1_raw = inst_addr_i;
        w_op2_raw = w_imm_u;
        w_legal   = 1'b1;
      end
      OPC_LOAD: begin
        w_rs1_use  = 1'b1;
        w_wen_raw  = 1'b1;
        w_mren_raw = 1'b1;
        w_op1_raw  = rs1_data_i;
        w_op2_raw  = w_imm_i;
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
          3'b011, 3'b110:                         w_legal = IS64;
          default:                                w_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_rs1_use   = 1'b1;
        w_rs2_use   = 1'b1;
        w_mwen_raw  = 1'b1;
        w_op1_raw   = rs1_data_i;
        w_op2_raw   = w_imm_s;
        w_sdata_raw = rs2_data_i;
        case (w_funct3)
          3'b000, 3'b001, 3'b010: w_legal = 1'b1;
          3'b011:                 w_legal = IS64;
          default:                w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal instructions carry no operands, destination or side effects
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_wen;
  logic [4:0]      w_rd_dec;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_sdata;

  assign w_rs1_used = w_legal && w_rs1_use;
  assign w_rs2_used = w_legal && w_rs2_use;
  assign w_wen      = w_legal && w_wen_raw;
  assign w_rd_dec   = w_wen ? w_rd : '0;
  assign w_op1      = w_legal ? w_op1_raw : '0;
  assign w_op2      = w_legal ? w_op2_raw : '0;
  assign w_sdata    = w_legal ? w_sdata_raw : '0;

  assign rs1_addr_o = w_rs1_used ? w_rs1 : '0;
  assign rs2_addr_o = w_rs2_used ? w_rs2 : '0;

  // Output register
  logic            r_valid;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_sdata;
  logic [4:0]      r_rd;
  logic            r_wen;
  logic            r_mren;
  logic            r_mwen;
  logic            r_illegal;
  logic [31:0]     r_stall_cnt;

  // A load in the output register whose rd feeds a source of the incoming
  // instruction blocks it until the load has been handed to EX.
  logic w_hazard;
  logic w_in_ready;
  logic w_accept;

  assign w_hazard = EN_LU_STALL && r_valid && r_mren && (r_rd != '0) && in_valid &&
                    ((w_rs1_used && w_rs1 == r_rd) || (w_rs2_used && w_rs2 == r_rd));
  assign w_in_ready = !rst && (!r_valid || out_ready) && !w_hazard && !flush_i;
  assign w_accept   = in_valid && w_in_ready;

  // Pipeline register: flush beats accept, accept beats hand-off, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_pc      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_sdata   <= '0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_mren    <= 1'b0;
      r_mwen    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_inst    <= inst_i;
      r_pc      <= inst_addr_i;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_sdata   <= w_sdata;
      r_rd      <= w_rd_dec;
      r_wen     <= w_wen;
      r_mren    <= w_legal && w_mren_raw;
      r_mwen    <= w_legal && w_mwen_raw;
      r_illegal <= !w_legal;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Load-use stall counter, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !flush_i) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_valid;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_pc;
  assign op1_o        = r_op1;
  assign op2_o        = r_op2;
  assign store_data_o = r_sdata;
  assign rd_addr_o    = r_rd;
  assign reg_wen      = r_wen;
  assign mem_ren_o    = r_mren;
  assign mem_wen_o    = r_mwen;
  assign illegal_o    = r_illegal;
  assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: two instances (full features, and no M /
// no load-use interlock) driven by independent randomized streams, with
// a reference decoder and a scoreboard checked by a separate monitor.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        wen;
    logic        mren;
    logic        mwen;
    logic        ill;
  } out_t;

  localparam int NCYC = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2], in_valid [2], in_ready [2], flush [2], out_valid [2], out_ready [2];
  logic        reg_wen [2], mren [2], mwen [2], ill [2];
  logic [31:0] inst_i [2], pc_i [2], d1 [2], d2 [2], inst_o [2], pc_o [2];
  logic [31:0] op1 [2], op2 [2], sd [2], scnt [2];
  logic [4:0]  rs1a [2], rs2a [2], rd [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_stage_pipe #(.XLEN(32), .EN_M(g == 0), .EN_LU_STALL(g == 0)) u_dut (
      .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .inst_i(inst_i[g]), .inst_addr_i(pc_i[g]),
      .rs1_addr_o(rs1a[g]), .rs2_addr_o(rs2a[g]),
      .rs1_data_i(d1[g]), .rs2_data_i(d2[g]), .flush_i(flush[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .inst_o(inst_o[g]), .inst_addr_o(pc_o[g]), .op1_o(op1[g]), .op2_o(op2[g]),
      .store_data_o(sd[g]), .rd_addr_o(rd[g]), .reg_wen(reg_wen[g]),
      .mem_ren_o(mren[g]), .mem_wen_o(mwen[g]), .illegal_o(ill[g]),
      .stall_cnt_o(scnt[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  out_t q0 [$];
  out_t q1 [$];

  logic [31:0] dir_list [8] = '{32'hFFF10093, 32'h0000A283, 32'h00528333, 32'h022081B3,
                                32'hFE20AE23, 32'h0000007F, 32'h4012D093, 32'h02009093};

  function automatic void q_push(input int k, input out_t r);
    if (k == 0) q0.push_back(r); else q1.push_back(r);
  endfunction
  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic out_t q_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void q_pop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction
  function automatic void q_drop_back(input int k);
    if (k == 0 && q0.size() > 0) void'(q0.pop_back());
    else if (k == 1 && q1.size() > 0) void'(q1.pop_back());
  endfunction
  function automatic void q_clear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic out_t dut_out(input int k);
    return {inst_o[k], pc_o[k], op1[k], op2[k], sd[k], rd[k], reg_wen[k], mren[k], mwen[k], ill[k]};
  endfunction

  task automatic check(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL dut%0d %s: got 0x%08h, want 0x%08h (t=%0t)", k, nm, act, exp, $time);
    end
  endtask

  task automatic check_rec(input int k, input string nm, input out_t a, input out_t e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL dut%0d %s: got inst=%08h pc=%08h op1=%08h op2=%08h sd=%08h rd=%0d wen=%b mren=%b mwen=%b ill=%b; want inst=%08h pc=%08h op1=%08h op2=%08h sd=%08h rd=%0d wen=%b mren=%b mwen=%b ill=%b",
               k, nm, a.inst, a.pc, a.op1, a.op2, a.sd, a.rd, a.wen, a.mren, a.mwen, a.ill,
               e.inst, e.pc, e.op1, e.op2, e.sd, e.rd, e.wen, e.mren, e.mwen, e.ill);
    end
  endtask

  // Reference decoder: classifies by opcode, checks funct legality from the
  // ISA tables and builds immediates with arithmetic shifts.
  function automatic out_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b, input bit en_m,
                                      output bit u1, output bit u2);
    out_t r;
    int unsigned opc, f3, f7;
    logic signed [31:0] s;
    logic [31:0] imm_i, imm_s, imm_u, imm_j;
    bit ok;
    opc = 32'(ins[6:0]);
    f3  = 32'(ins[14:12]);
    f7  = 32'(ins[31:25]);
    s = ins;
    imm_i = 32'(s >>> 20);
    imm_s = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    imm_u = ins & 32'hFFFF_F000;
    imm_j = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    r = '0; r.inst = ins; r.pc = pc;
    ok = 0; u1 = 0; u2 = 0;
    case (opc)
      'h13: begin
        u1 = 1; r.wen = 1; r.op1 = a;
        if (f3 == 1 || f3 == 5) begin
          r.op2 = 32'(ins[24:20]);
          ok = (f7 == 0) || (f3 == 5 && f7 == 'h20);
        end else begin
          r.op2 = imm_i; ok = 1;
        end
      end
      'h33: begin
        u1 = 1; u2 = 1; r.wen = 1; r.op1 = a; r.op2 = b;
        ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m);
      end
      'h63: begin u1 = 1; u2 = 1; r.op1 = a; r.op2 = b; ok = !(f3 == 2 || f3 == 3); end
      'h6F: begin r.wen = 1; r.op1 = imm_j; ok = 1; end
      'h67: begin u1 = 1; r.wen = 1; r.op1 = a; r.op2 = imm_i; ok = (f3 == 0); end
      'h37: begin r.wen = 1; r.op1 = imm_u; ok = 1; end
      'h17: begin r.wen = 1; r.op1 = pc; r.op2 = imm_u; ok = 1; end
      'h03: begin
        u1 = 1; r.wen = 1; r.mren = 1; r.op1 = a; r.op2 = imm_i;
        ok = (f3 <= 2) || f3 == 4 || f3 == 5;
      end
      'h23: begin
        u1 = 1; u2 = 1; r.mwen = 1; r.op1 = a; r.op2 = imm_s; r.sd = b; ok = (f3 <= 2);
      end
      default: ok = 0;
    endcase
    if (r.wen) r.rd = ins[11:7];
    if (!ok) begin
      r.op1 = '0; r.op2 = '0; r.sd = '0; r.rd = '0;
      r.wen = 0; r.mren = 0; r.mwen = 0; r.ill = 1;
      u1 = 0; u2 = 0;
    end
    return r;
  endfunction

  // Small register numbers so load-use dependencies occur often
  function automatic logic [31:0] rand_inst();
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [31:0] ins;
    case ($urandom_range(0, 11))
      0, 1:    op = 7'h03;
      2:       op = 7'h13;
      3, 4:    op = 7'h33;
      5:       op = 7'h63;
      6:       op = 7'h6F;
      7:       op = 7'h67;
      8:       op = 7'h37;
      9:       op = 7'h17;
      10:      op = 7'h23;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      3:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    ins = $urandom;
    ins[6:0]   = op;
    ins[31:25] = f7;
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  // Stimulus plus cycle-level handshake model for one instance
  task automatic drive(input int k);
    bit mv = 0, have = 0, after_rst = 0, en = (k == 0);
    bit u1, u2, haz, rdy, rphase;
    out_t mrec = '0, rec;
    logic [31:0] mcnt = '0, cur = '0, pc = 32'h0000_1000;
    int di = 0;
    for (int c = 0; c < NCYC; c++) begin
      rphase = (c >= 30);
      rst[k] = (c < 2) || (c == 700);
      if (!have) begin
        cur = (di < 8) ? dir_list[di] : rand_inst();
        di++; have = 1; pc += 4;
      end
      in_valid[k]  = rphase ? ($urandom_range(0, 4) != 0) : 1'b1;
      inst_i[k]    = cur;
      pc_i[k]      = pc;
      d1[k]        = $urandom;
      d2[k]        = $urandom;
      out_ready[k] = rphase ? ($urandom_range(0, 3) != 0) : 1'b1;
      flush[k]     = rphase && ($urandom_range(0, 15) == 0);
      rec = ref_decode(cur, pc, d1[k], d2[k], en, u1, u2);
      haz = en && mv && mrec.mren && (mrec.rd != 0) && in_valid[k] &&
            ((u1 && cur[19:15] == mrec.rd) || (u2 && cur[24:20] == mrec.rd));
      rdy = !rst[k] && (!mv || out_ready[k]) && !haz && !flush[k];
      @(negedge clk);
      if (c > 0) begin
        check(k, "in_ready", 32'(in_ready[k]), 32'(rdy));
        check(k, "out_valid", 32'(out_valid[k]), 32'(mv));
        check(k, "stall_cnt", scnt[k], mcnt);
        check(k, "rs1_addr", 32'(rs1a[k]), u1 ? 32'(cur[19:15]) : 32'd0);
        check(k, "rs2_addr", 32'(rs2a[k]), u2 ? 32'(cur[24:20]) : 32'd0);
        if (after_rst) check_rec(k, "reset_regs", dut_out(k), '0);
      end
      @(posedge clk); #1;
      if (rst[k]) begin
        mv = 0; mcnt = '0; mrec = '0; after_rst = 1; q_clear(k);
      end else begin
        after_rst = 0;
        if (haz && !flush[k]) mcnt++;
        if (flush[k]) begin
          if (mv) q_drop_back(k);
          mv = 0; have = 0;
        end else if (in_valid[k] && rdy) begin
          q_push(k, rec); mrec = rec; mv = 1; have = 0;
        end else if (mv && out_ready[k]) begin
          mv = 0;
        end
      end
    end
  endtask

  // Compares every presented output against the scoreboard head; pops on hand-off
  task automatic monitor(input int k);
    forever begin
      @(negedge clk);
      if (rst[k] === 1'b0 && out_valid[k] === 1'b1) begin
        if (q_size(k) == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dut%0d unexpected_output: got out_valid=1 inst=%08h, want no pending entry", k, inst_o[k]);
        end else begin
          check_rec(k, "decoded", dut_out(k), q_front(k));
          if (out_ready[k] && !flush[k]) q_pop(k);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    fork
      drive(0);
      drive(1);
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(NCYC * 10 * 4);
    $display("FAIL timeout: got no completion, want finish within %0d cycles", NCYC * 4);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised RV decode stage with a valid/ready handshake on both sides.
- Sits between the fetch/IF-ID buffer and EX, replacing the purely combinational decoder plus separate ID/EX register.
- Adds load/store decode, optional M-extension decode, illegal-instruction flagging, load-use hazard stalling, flush, and a stall performance counter.

Parameters:
- XLEN, 32, datapath width; 32 or 64. Immediates are sign-extended to XLEN; shamt width is 5 (XLEN=32) or 6 (XLEN=64).
- EN_M, 1, 1 = accept MUL/DIV group (opcode R, funct7=0000001); 0 = flag it illegal.
- EN_LU_STALL, 1, 1 = enable load-use interlock; 0 = never stall on hazard (forwarding handled elsewhere).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- inst_i  in  32  instruction word
- inst_addr_i  in  XLEN  instruction PC
- rs1_addr_o  out  5  regfile read address 1, combinational from inst_i
- rs2_addr_o  out  5  regfile read address 2, combinational from inst_i
- rs1_data_i  in  XLEN  regfile data 1, same cycle
- rs2_data_i  in  XLEN  regfile data 2, same cycle
- flush_i  in  1  branch/jump redirect; kill in-flight and incoming
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  EX accepts
- inst_o  out  32  registered instruction
- inst_addr_o  out  XLEN  registered PC
- op1_o  out  XLEN  operand 1
- op2_o  out  XLEN  operand 2
- store_data_o  out  XLEN  rs2 data for stores, else 0
- rd_addr_o  out  5  destination register
- reg_wen  out  1  write-back enable
- mem_ren_o  out  1  load
- mem_wen_o  out  1  store
- illegal_o  out  1  undecodable instruction
- stall_cnt_o  out  32  load-use stall cycle counter

Behaviour:
- Reset: out_valid=0; all registered outputs=0; stall_cnt_o=0. in_ready is 0 during the rst cycle.
- Accept: accept = in_valid && in_ready. Decoded fields are registered on accept, giving 1-cycle latency from accept to out_valid.
- in_ready = (!out_valid || out_ready) && !hazard && !flush_i.
- Output register update priority:
  - flush_i clears out_valid.
  - Otherwise, accept loads new contents with out_valid=1.
  - Otherwise, out_valid && out_ready clears out_valid.
  - Otherwise, hold. All outputs stay stable while out_valid && !out_ready.
- hazard:
  - Condition: EN_LU_STALL && out_valid && mem_ren_o && rd_addr_o!=0 && in_valid && (rs1 used && rs1==rd_addr_o || rs2 used && rs2==rd_addr_o).
  - rs1 is used by I-ALU, R/M, B, JALR, load, store. rs2 is used by R/M, B, store.
  - A handed-off load empties the register, so the dependent instruction is accepted one cycle later. This yields exactly one bubble.
- stall_cnt_o: increments by 1 on each cycle where hazard=1 and !flush_i. Wraps at 2^32-1 to 0.
- Decode (registered values):
  - I-ALU: op1=rs1, op2=sext(imm[11:0]), wen=1.
  - SLLI/SRLI/SRAI: op2=zext(shamt). For XLEN=32, inst[25]=1 is illegal. funct7[6:1] must be 0 or 010000.
  - R: funct7 must be 0000000, or 0100000 (ADD/SUB, SR only). op1=rs1, op2=rs2, wen=1.
  - M (EN_M=1, funct7=0000001): same operand routing as R, wen=1.
  - B: funct3 in {0,1,4,5,6,7}. op1=rs1, op2=rs2, wen=0.
  - JAL: op1=sext(J-imm), wen=1.
  - JALR (funct3=0): op1=rs1, op2=sext(I-imm), wen=1.
  - LUI: op1={imm[31:12],12'b0} sign-extended, wen=1.
  - AUIPC: op1=PC, op2=sext({imm[31:12],12'b0}), wen=1.
  - LOAD: funct3 in {0,1,2,4,5}; for XLEN=64, also {3,6}. op1=rs1, op2=sext(I-imm), wen=1, mem_ren=1.
  - STORE: funct3 in {0,1,2}; for XLEN=64, also {3}. op1=rs1, op2=sext(S-imm), store_data=rs2, wen=0, rd=0, mem_wen=1.
- rs addresses for unused sources are driven as 0.
- Illegal (unknown opcode/funct): illegal_o=1, reg_wen=mem_ren=mem_wen=0, op1=op2=rd=0. inst_o and inst_addr_o are preserved. The instruction still passes with out_valid=1 for trap handling.
- rd=x0 with wen=1 is passed through unchanged.
- rst asserted mid-operation: discards the held instruction. The counter clears.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), rs1_data=0x10, out_ready=1 -> next cycle out_valid=1, op1=0x10, op2=0xFFFFFFFF, rd=1, reg_wen=1, rs1_addr_o=2 combinationally.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333) back-to-back -> ADD sees in_ready=0 for 1 cycle; output sequence is load, bubble, ADD; stall_cnt_o=1. With EN_LU_STALL=0: no bubble, counter stays 0.
- Valid instruction held, out_ready=0 for 3 cycles -> all outputs stable, in_ready=0; releasing out_ready accepts the next instruction the same cycle.
- flush_i asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not consumed, stall_cnt_o unchanged.
- MUL x3,x1,x2 (0x022081B3) with EN_M=0 -> illegal_o=1, reg_wen=0. With EN_M=1 -> illegal_o=0, reg_wen=1, rd=3.
- SW x2,-4(x1) (0xFE20AE23), rs2_data=0xAB -> mem_wen_o=1, op2=0xFFFFFFFC, store_data_o=0xAB, reg_wen=0. Opcode 0x7F -> illegal_o=1. Assert rst -> all outputs 0.
